// File: rtl/plab4_net_router_input_queue_nf_pkg.sv
// Shared ring-network message layout and helpers for the router input queue.
// Optional bypass path is enabled by defining PLAB4_NET_INPUT_QUEUE_BYPASS_EN.
package plab4_net_router_input_queue_nf_pkg;

    localparam int c_net_num_routers = 8;

    localparam int c_net_msg_payload_lsb   = 0;
    localparam int c_net_msg_payload_nbits = 32;
    localparam int c_net_msg_dest_lsb      = 32;
    localparam int c_net_msg_dest_nbits    = 3;
    localparam int c_net_msg_src_lsb       = 35;
    localparam int c_net_msg_src_nbits     = 3;
    localparam int c_net_msg_opaque_lsb    = 38;
    localparam int c_net_msg_opaque_nbits  = 6;
    localparam int c_net_msg_nbits         = 44;

    // Field order is MSB first so the packed struct matches the lsb constants above.
    typedef struct packed {
        logic [c_net_msg_opaque_nbits-1:0]  opaque;
        logic [c_net_msg_src_nbits-1:0]     src;
        logic [c_net_msg_dest_nbits-1:0]    dest;
        logic [c_net_msg_payload_nbits-1:0] payload;
    } net_msg_t;

    function automatic net_msg_t mk_net_msg(
        input logic [c_net_msg_dest_nbits-1:0]    dest,
        input logic [c_net_msg_src_nbits-1:0]     src,
        input logic [c_net_msg_opaque_nbits-1:0]  opaque,
        input logic [c_net_msg_payload_nbits-1:0] payload
    );
        net_msg_t m;
        m.opaque  = opaque;
        m.src     = src;
        m.dest    = dest;
        m.payload = payload;
        return m;
    endfunction

    // Pointer width for a queue of n entries; never zero so depth-1 corner stays legal.
    function automatic int nf_ptr_nbits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plab4_net_router_input_queue_nf_ctrl.sv
// Input queue control: pointers, occupancy, registered free count, val/rdy and bypass select.
// Bypass select is only live when PLAB4_NET_INPUT_QUEUE_BYPASS_EN is defined.
module plab4_net_router_input_queue_nf_ctrl
    import plab4_net_router_input_queue_nf_pkg::*;
#(
    parameter int p_num_entries    = 4,
    parameter int p_num_free_nbits = 3,
    parameter int p_ptr_nbits      = 2
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enq_val,
    output logic                        enq_rdy,
    output logic                        deq_val,
    input  logic                        deq_rdy,
    output logic                        wr_en,
    output logic [p_ptr_nbits-1:0]      wr_ptr,
    output logic [p_ptr_nbits-1:0]      rd_ptr,
    output logic                        bypass_sel,
    output logic [p_num_free_nbits-1:0] num_free
);

    localparam int c_cnt_nbits = $clog2(p_num_entries + 1);

    localparam logic [c_cnt_nbits-1:0]      c_full     = c_cnt_nbits'(p_num_entries);
    localparam logic [c_cnt_nbits-1:0]      c_cnt_one  = c_cnt_nbits'(1);
    localparam logic [p_ptr_nbits-1:0]      c_ptr_last = p_ptr_nbits'(p_num_entries - 1);
    localparam logic [p_ptr_nbits-1:0]      c_ptr_one  = p_ptr_nbits'(1);
    localparam logic [p_num_free_nbits-1:0] c_nf_full  = p_num_free_nbits'(p_num_entries);

    logic [c_cnt_nbits-1:0] count;
    logic [c_cnt_nbits-1:0] count_next;
    logic [p_ptr_nbits-1:0] wr_ptr_next;
    logic [p_ptr_nbits-1:0] rd_ptr_next;
    logic                   empty;
    logic                   enq_fire;
    logic                   deq_fire;

    always_comb begin
        empty = (count == '0);
`ifdef PLAB4_NET_INPUT_QUEUE_BYPASS_EN
        bypass_sel = reset & empty & enq_val;
`else
        bypass_sel = 1'b0;
`endif
        enq_rdy  = reset & (count < c_full);
        deq_val  = reset & (~empty | bypass_sel);
        enq_fire = enq_val & enq_rdy;
        // Only stored entries are dequeued; a bypassed msg consumed at once never lands.
        deq_fire = reset & ~empty & deq_rdy;
        wr_en    = enq_fire & ~(bypass_sel & deq_rdy);
    end

    always_comb begin
        count_next = count;
        case ({wr_en, deq_fire})
            2'b10:   count_next = count + c_cnt_one;
            2'b01:   count_next = count - c_cnt_one;
            default: count_next = count;
        endcase

        wr_ptr_next = wr_ptr;
        if (wr_en)
            wr_ptr_next = (wr_ptr == c_ptr_last) ? '0 : wr_ptr + c_ptr_one;

        rd_ptr_next = rd_ptr;
        if (deq_fire)
            rd_ptr_next = (rd_ptr == c_ptr_last) ? '0 : rd_ptr + c_ptr_one;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            num_free <= c_nf_full;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            num_free <= c_nf_full - p_num_free_nbits'(count_next);
        end
    end

endmodule

// File: rtl/plab4_net_router_input_queue_nf.sv
// Ring router per-input-port message queue: entry storage and head mux around the ctrl.
// Define PLAB4_NET_INPUT_QUEUE_BYPASS_EN for a same-cycle enq->deq path when empty.
module plab4_net_router_input_queue_nf
    import plab4_net_router_input_queue_nf_pkg::*;
#(
    parameter int p_msg_nbits      = c_net_msg_nbits,
    parameter int p_num_entries    = 4,
    parameter int p_num_free_nbits = 3,
    parameter int p_num_routers    = c_net_num_routers,
    parameter int p_dest_lsb       = c_net_msg_dest_lsb
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enq_val,
    output logic                             enq_rdy,
    input  logic [p_msg_nbits-1:0]           enq_msg,
    output logic                             deq_val,
    input  logic                             deq_rdy,
    output logic [p_msg_nbits-1:0]           deq_msg,
    output logic [$clog2(p_num_routers)-1:0] deq_dest,
    output logic [p_num_free_nbits-1:0]      num_free
);

    localparam int c_dest_nbits = $clog2(p_num_routers);
    localparam int c_ptr_nbits  = nf_ptr_nbits(p_num_entries);

    logic                     wr_en;
    logic [c_ptr_nbits-1:0]   wr_ptr;
    logic [c_ptr_nbits-1:0]   rd_ptr;
    logic                     bypass_sel;
    logic [p_num_entries-1:0] entry_we;
    logic [p_msg_nbits-1:0]   entries [p_num_entries];

    plab4_net_router_input_queue_nf_ctrl #(
        .p_num_entries    (p_num_entries),
        .p_num_free_nbits (p_num_free_nbits),
        .p_ptr_nbits      (c_ptr_nbits)
    ) ctrl (
        .clk        (clk),
        .reset      (reset),
        .enq_val    (enq_val),
        .enq_rdy    (enq_rdy),
        .deq_val    (deq_val),
        .deq_rdy    (deq_rdy),
        .wr_en      (wr_en),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .bypass_sel (bypass_sel),
        .num_free   (num_free)
    );

    always_comb begin
        entry_we = '0;
        for (int i = 0; i < p_num_entries; i++)
            entry_we[i] = wr_en && (wr_ptr == c_ptr_nbits'(i));
    end

    // Storage needs no reset: the ctrl's count decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_num_entries; i++)
            if (entry_we[i])
                entries[i] <= enq_msg;
    end

    always_comb begin
        deq_msg = bypass_sel ? enq_msg : entries[rd_ptr];
    end

    assign deq_dest = deq_msg[p_dest_lsb +: c_dest_nbits];

endmodule
